// File: rtl/mitigation_stream_mux.sv
// mitigation_stream_mux: packet-atomic round-robin merge of the mitigation data
// stream and the marker keep-alive stream onto one registered DMA stream.
// Packets longer than MAX_BEATS are cut short with a forced TLAST, and the rest
// of the source packet is drained and discarded.
module mitigation_stream_mux #(
    parameter int unsigned AXI_WIDTH   = 32,
    parameter int unsigned MAX_BEATS   = 1024,
    parameter int unsigned COUNT_WIDTH = 16,
    parameter string       DEBUG       = "false"
) (
    input  logic                   sysClk,
    input  logic                   sysReset,
    (* mark_debug = DEBUG *) input  logic [AXI_WIDTH-1:0] sysDataTDATA,
    (* mark_debug = DEBUG *) input  logic                 sysDataTVALID,
    (* mark_debug = DEBUG *) input  logic                 sysDataTLAST,
    (* mark_debug = DEBUG *) output logic                 sysDataTREADY,
    (* mark_debug = DEBUG *) input  logic [AXI_WIDTH-1:0] sysMarkerTDATA,
    (* mark_debug = DEBUG *) input  logic                 sysMarkerTVALID,
    (* mark_debug = DEBUG *) input  logic                 sysMarkerTLAST,
    (* mark_debug = DEBUG *) output logic                 sysMarkerTREADY,
    (* mark_debug = DEBUG *) output logic [AXI_WIDTH-1:0] sysDmaTDATA,
    (* mark_debug = DEBUG *) output logic                 sysDmaTVALID,
    (* mark_debug = DEBUG *) output logic                 sysDmaTLAST,
    (* mark_debug = DEBUG *) input  logic                 sysDmaTREADY,
    output logic [COUNT_WIDTH-1:0] sysDataPackets,
    output logic [COUNT_WIDTH-1:0] sysMarkerPackets,
    output logic [COUNT_WIDTH-1:0] sysTruncCount
);

    localparam int unsigned BEAT_W = $clog2(MAX_BEATS);
    localparam logic [BEAT_W-1:0] LAST_SLOT = BEAT_W'(MAX_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT_DATA,
        GRANT_MARKER,
        DRAIN
    } state_t;

    (* mark_debug = DEBUG *) state_t state;

    // Owner of the current (or most recent) grant; 1 = marker.
    logic              grantMarker;
    logic [BEAT_W-1:0] beatCount;

    logic                 outReady;
    logic                 inGrant;
    logic                 selValid;
    logic                 selReady;
    logic                 selLast;
    logic [AXI_WIDTH-1:0] selData;
    logic                 accept;
    logic                 lastSlot;

    // Output buffer can take a beat when empty or draining this cycle.
    assign outReady = !sysDmaTVALID || sysDmaTREADY;
    assign inGrant  = (state == GRANT_DATA) || (state == GRANT_MARKER);

    // Slave ready: follows the output buffer while granted, forced high while draining.
    assign sysDataTREADY   = ((state == GRANT_DATA) && outReady) ||
                             ((state == DRAIN) && !grantMarker);
    assign sysMarkerTREADY = ((state == GRANT_MARKER) && outReady) ||
                             ((state == DRAIN) && grantMarker);

    // Granted-slave beat selection.
    assign selValid = grantMarker ? sysMarkerTVALID : sysDataTVALID;
    assign selReady = grantMarker ? sysMarkerTREADY : sysDataTREADY;
    assign selLast  = grantMarker ? sysMarkerTLAST  : sysDataTLAST;
    assign selData  = grantMarker ? sysMarkerTDATA  : sysDataTDATA;
    assign accept   = selValid && selReady;
    assign lastSlot = (beatCount == LAST_SLOT);

    // Single output register stage; holds its beat while the DMA side stalls.
    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            sysDmaTVALID <= 1'b0;
            sysDmaTLAST  <= 1'b0;
            sysDmaTDATA  <= '0;
        end else if (outReady) begin
            sysDmaTVALID <= accept && inGrant;
            if (accept && inGrant) begin
                sysDmaTDATA <= selData;
                sysDmaTLAST <= selLast || lastSlot;
            end
        end
    end

    // Arbitration, beat counting, truncation and statistics.
    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            state            <= IDLE;
            grantMarker      <= 1'b1;
            beatCount        <= '0;
            sysDataPackets   <= '0;
            sysMarkerPackets <= '0;
            sysTruncCount    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    beatCount <= '0;
                    if (sysDataTVALID && (!sysMarkerTVALID || grantMarker)) begin
                        state       <= GRANT_DATA;
                        grantMarker <= 1'b0;
                    end else if (sysMarkerTVALID) begin
                        state       <= GRANT_MARKER;
                        grantMarker <= 1'b1;
                    end
                end
                GRANT_DATA, GRANT_MARKER: begin
                    if (accept) begin
                        if (selLast) begin
                            state <= IDLE;
                            if (grantMarker) begin
                                sysMarkerPackets <= sysMarkerPackets + COUNT_WIDTH'(1);
                            end else begin
                                sysDataPackets <= sysDataPackets + COUNT_WIDTH'(1);
                            end
                        end else if (lastSlot) begin
                            state <= DRAIN;
                            if (sysTruncCount != '1) begin
                                sysTruncCount <= sysTruncCount + COUNT_WIDTH'(1);
                            end
                        end else begin
                            beatCount <= beatCount + BEAT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (accept && selLast) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mitigation_stream_mux.sv
// Bench for mitigation_stream_mux: packet-level model of the merged output
// stream and statistics, checked beat by beat, plus literal expectations.
module tb_mitigation_stream_mux;

    localparam int unsigned W    = 32;
    localparam int unsigned MAXB = 4;
    localparam int unsigned CW   = 16;

    logic          sysClk = 1'b0;
    logic          sysReset;
    logic [W-1:0]  sysDataTDATA;
    logic          sysDataTVALID;
    logic          sysDataTLAST;
    logic          sysDataTREADY;
    logic [W-1:0]  sysMarkerTDATA;
    logic          sysMarkerTVALID;
    logic          sysMarkerTLAST;
    logic          sysMarkerTREADY;
    logic [W-1:0]  sysDmaTDATA;
    logic          sysDmaTVALID;
    logic          sysDmaTLAST;
    logic          sysDmaTREADY;
    logic [CW-1:0] sysDataPackets;
    logic [CW-1:0] sysMarkerPackets;
    logic [CW-1:0] sysTruncCount;

    mitigation_stream_mux #(
        .AXI_WIDTH  (W),
        .MAX_BEATS  (MAXB),
        .COUNT_WIDTH(CW),
        .DEBUG      ("false")
    ) dut (
        .sysClk          (sysClk),
        .sysReset        (sysReset),
        .sysDataTDATA    (sysDataTDATA),
        .sysDataTVALID   (sysDataTVALID),
        .sysDataTLAST    (sysDataTLAST),
        .sysDataTREADY   (sysDataTREADY),
        .sysMarkerTDATA  (sysMarkerTDATA),
        .sysMarkerTVALID (sysMarkerTVALID),
        .sysMarkerTLAST  (sysMarkerTLAST),
        .sysMarkerTREADY (sysMarkerTREADY),
        .sysDmaTDATA     (sysDmaTDATA),
        .sysDmaTVALID    (sysDmaTVALID),
        .sysDmaTLAST     (sysDmaTLAST),
        .sysDmaTREADY    (sysDmaTREADY),
        .sysDataPackets  (sysDataPackets),
        .sysMarkerPackets(sysMarkerPackets),
        .sysTruncCount   (sysTruncCount)
    );

    always #5 sysClk = ~sysClk;

    // Slave beat queues as {last, data}, pending packet descriptors, and model output.
    logic [W:0]   dataQ[$];
    logic [W:0]   markerQ[$];
    int           dataLen[$];
    int           markerLen[$];
    logic [W-1:0] dataBase[$];
    logic [W-1:0] markerBase[$];
    logic [W:0]   expQ[$];
    logic [W:0]   outLog[$];
    int           outCyc[$];

    int nVec = 0;
    int nErr = 0;
    int cyc  = 0;

    bit modelLastMarker;
    int mDataPkts;
    int mMarkerPkts;
    int mTrunc;
    bit dmaToggle;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Queue one packet on a slave and remember it for the model.
    task automatic addPkt(input bit isMarker, input int n, input logic [W-1:0] base);
        for (int i = 0; i < n; i++) begin
            if (isMarker) markerQ.push_back({(i == n - 1), base + W'(i)});
            else          dataQ.push_back({(i == n - 1), base + W'(i)});
        end
        if (isMarker) begin
            markerLen.push_back(n);
            markerBase.push_back(base);
        end else begin
            dataLen.push_back(n);
            dataBase.push_back(base);
        end
    endtask

    // Model: whole packets in round-robin order, truncated to MAXB beats.
    task automatic buildExpected();
        bit           pickMarker;
        int           n;
        int           kept;
        logic [W-1:0] base;
        while (dataLen.size() > 0 || markerLen.size() > 0) begin
            if (dataLen.size() > 0 && markerLen.size() > 0) pickMarker = !modelLastMarker;
            else pickMarker = (markerLen.size() > 0);
            modelLastMarker = pickMarker;
            if (pickMarker) begin
                n    = markerLen.pop_front();
                base = markerBase.pop_front();
            end else begin
                n    = dataLen.pop_front();
                base = dataBase.pop_front();
            end
            kept = (n > int'(MAXB)) ? int'(MAXB) : n;
            for (int i = 0; i < kept; i++) expQ.push_back({(i == kept - 1), base + W'(i)});
            if (n > int'(MAXB)) begin
                if (mTrunc < (1 << CW) - 1) mTrunc++;
            end else if (pickMarker) begin
                mMarkerPkts++;
            end else begin
                mDataPkts++;
            end
        end
    endtask

    // Present the head of each slave queue.
    task automatic drive();
        sysDataTVALID   = (dataQ.size() > 0);
        {sysDataTLAST, sysDataTDATA}     = (dataQ.size() > 0) ? dataQ[0] : '0;
        sysMarkerTVALID = (markerQ.size() > 0);
        {sysMarkerTLAST, sysMarkerTDATA} = (markerQ.size() > 0) ? markerQ[0] : '0;
    endtask

    // One clock: note slave handshakes mid-cycle, then advance after the edge.
    task automatic cycle();
        bit dAcc;
        bit mAcc;
        @(negedge sysClk);
        dAcc = sysDataTVALID && sysDataTREADY;
        mAcc = sysMarkerTVALID && sysMarkerTREADY;
        @(posedge sysClk);
        #1;
        if (dAcc) void'(dataQ.pop_front());
        if (mAcc) void'(markerQ.pop_front());
        if (dmaToggle) sysDmaTREADY = ~sysDmaTREADY;
        drive();
    endtask

    task automatic runUntilIdle(input string name, input int budget);
        int k;
        k = 0;
        while (!(dataQ.size() == 0 && markerQ.size() == 0 && expQ.size() == 0 && !sysDmaTVALID)
               && k < budget) begin
            cycle();
            k++;
        end
        check({name, " completes"}, 64'(k < budget), 64'(1));
    endtask

    task automatic checkStats(input string name);
        check({name, " dataPkts model"},   64'(sysDataPackets),   64'(mDataPkts));
        check({name, " markerPkts model"}, 64'(sysMarkerPackets), 64'(mMarkerPkts));
        check({name, " trunc model"},      64'(sysTruncCount),    64'(mTrunc));
    endtask

    // Assert reset, abandon all traffic, and check reset values while held.
    task automatic doReset();
        sysReset = 1'b1;
        dataQ.delete(); markerQ.delete();
        dataLen.delete(); markerLen.delete();
        dataBase.delete(); markerBase.delete();
        expQ.delete(); outLog.delete(); outCyc.delete();
        modelLastMarker = 1'b1;
        mDataPkts = 0; mMarkerPkts = 0; mTrunc = 0;
        dmaToggle = 1'b0;
        sysDmaTREADY = 1'b1;
        drive();
        repeat (2) @(posedge sysClk);
        #1;
        check("reset TVALID", 64'(sysDmaTVALID), 64'(0));
        check("reset TLAST",  64'(sysDmaTLAST),  64'(0));
        check("reset TDATA",  64'(sysDmaTDATA),  64'(0));
        check("reset readies", 64'({sysDataTREADY, sysMarkerTREADY}), 64'(0));
        check("reset stats", 64'({sysDataPackets, sysMarkerPackets, sysTruncCount}), 64'(0));
        sysReset = 1'b0;
    endtask

    // Compare process: every accepted output beat against the model; stall stability.
    logic       prevStall = 1'b0;
    logic [W:0] prevBeat;
    always @(negedge sysClk) begin
        cyc++;
        if (sysReset) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                check("stall TVALID held", 64'(sysDmaTVALID), 64'(1));
                check("stall beat held", 64'({sysDmaTLAST, sysDmaTDATA}), 64'(prevBeat));
            end
            if (sysDmaTVALID && sysDmaTREADY) begin
                if (expQ.size() == 0) begin
                    nVec++;
                    nErr++;
                    $display("FAIL unexpected beat: got 0x%0h, required none", {sysDmaTLAST, sysDmaTDATA});
                end else begin
                    check("dma beat", 64'({sysDmaTLAST, sysDmaTDATA}), 64'(expQ.pop_front()));
                end
                outLog.push_back({sysDmaTLAST, sysDmaTDATA});
                outCyc.push_back(cyc);
            end
            prevStall = sysDmaTVALID && !sysDmaTREADY;
            prevBeat  = {sysDmaTLAST, sysDmaTDATA};
        end
    end

    initial begin
        int k;
        sysReset = 1'b1;
        sysDmaTREADY = 1'b1;

        // Marker-only 3-beat packet A,B,C at full rate.
        doReset();
        addPkt(1'b1, 3, 32'hA);
        buildExpected();
        drive();
        runUntilIdle("marker3", 50);
        check("marker3 beats", 64'(outLog.size()), 64'(3));
        if (outLog.size() == 3) begin
            check("marker3 A", 64'(outLog[0]), 64'({1'b0, 32'hA}));
            check("marker3 C last", 64'(outLog[2]), 64'({1'b1, 32'hC}));
            check("marker3 back-to-back", 64'(outCyc[2] - outCyc[0]), 64'(2));
        end
        check("marker3 markerPkts", 64'(sysMarkerPackets), 64'(1));
        checkStats("marker3");

        // Both slaves pending from reset: data wins first tie, then alternates.
        doReset();
        addPkt(1'b0, 1, 32'h1100);
        addPkt(1'b0, 3, 32'h1200);
        addPkt(1'b0, 2, 32'h1300);
        addPkt(1'b1, 2, 32'h2100);
        addPkt(1'b1, 1, 32'h2200);
        addPkt(1'b1, 4, 32'h2300);
        buildExpected();
        drive();
        runUntilIdle("roundrobin", 200);
        check("rr beats", 64'(outLog.size()), 64'(13));
        if (outLog.size() == 13) begin
            check("rr first is data", 64'(outLog[0]), 64'({1'b1, 32'h1100}));
            check("rr second is marker", 64'(outLog[1]), 64'({1'b0, 32'h2100}));
            check("rr final marker beat", 64'(outLog[12]), 64'({1'b1, 32'h2303}));
        end
        check("rr counts", 64'({sysDataPackets, sysMarkerPackets}), 64'({16'd3, 16'd3}));
        checkStats("roundrobin");

        // DMA ready toggling every cycle during a 4-beat data packet.
        doReset();
        dmaToggle = 1'b1;
        addPkt(1'b0, 4, 32'h3000);
        buildExpected();
        drive();
        runUntilIdle("toggle", 100);
        dmaToggle = 1'b0;
        sysDmaTREADY = 1'b1;
        check("toggle beats", 64'(outLog.size()), 64'(4));
        if (outLog.size() == 4) begin
            check("toggle first", 64'(outLog[0]), 64'({1'b0, 32'h3000}));
            check("toggle last", 64'(outLog[3]), 64'({1'b1, 32'h3003}));
        end
        checkStats("toggle");

        // 6-beat data packet with MAX_BEATS=4: truncated and drained.
        doReset();
        addPkt(1'b0, 6, 32'hD0);
        buildExpected();
        drive();
        runUntilIdle("trunc", 100);
        check("trunc beats", 64'(outLog.size()), 64'(4));
        if (outLog.size() == 4) check("trunc forced last D3", 64'(outLog[3]), 64'({1'b1, 32'hD3}));
        check("trunc count", 64'(sysTruncCount), 64'(1));
        check("trunc dataPkts", 64'(sysDataPackets), 64'(0));
        checkStats("trunc");

        // Exactly MAX_BEATS beats: intact, not truncated.
        doReset();
        addPkt(1'b0, 4, 32'h40);
        buildExpected();
        drive();
        runUntilIdle("exact", 100);
        check("exact beats", 64'(outLog.size()), 64'(4));
        check("exact trunc", 64'(sysTruncCount), 64'(0));
        check("exact dataPkts", 64'(sysDataPackets), 64'(1));
        checkStats("exact");

        // Reset after beat 2 of a 5-beat packet, then a fresh 2-beat marker packet.
        doReset();
        addPkt(1'b0, 5, 32'h50);
        buildExpected();
        drive();
        k = 0;
        while (dataQ.size() > 3 && k < 20) begin
            cycle();
            k++;
        end
        check("midreset reached beat 2", 64'(k < 20), 64'(1));
        doReset();
        addPkt(1'b1, 2, 32'h60);
        buildExpected();
        drive();
        runUntilIdle("after reset", 50);
        check("after reset beats", 64'(outLog.size()), 64'(2));
        if (outLog.size() == 2) begin
            check("after reset M0", 64'(outLog[0]), 64'({1'b0, 32'h60}));
            check("after reset M1", 64'(outLog[1]), 64'({1'b1, 32'h61}));
        end
        check("after reset stats", 64'({sysDataPackets, sysMarkerPackets, sysTruncCount}),
              64'({16'd0, 16'd1, 16'd0}));
        checkStats("after reset");

        repeat (3) @(posedge sysClk);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

    // Absolute time bound in case the design wedges the bench.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mitigation_stream_mux.md
MITIGATION_STREAM_MUX -- requirements
Module: mitigation_stream_mux

Interface
REQ-001 SHALL have parameter AXI_WIDTH, default 32, stream data width in bits.
REQ-002 SHALL have parameter MAX_BEATS, default 1024, maximum beats per output packet (legal range 2..65535).
REQ-003 SHALL have parameter COUNT_WIDTH, default 16, width of the statistics counters.
REQ-004 SHALL have parameter DEBUG, default "false", applied as mark_debug to all stream ports and the state register.
REQ-005 SHALL have port sysClk, input, 1, the single clock; all logic is in this domain.
REQ-006 SHALL have port sysReset, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have ports sysDataTDATA/TVALID/TLAST (input, AXI_WIDTH/1/1) and sysDataTREADY (output, 1): slave 0, the mitigation data stream.
REQ-008 SHALL have ports sysMarkerTDATA/TVALID/TLAST (input, AXI_WIDTH/1/1) and sysMarkerTREADY (output, 1): slave 1, the marker keep-alive stream.
REQ-009 SHALL have ports sysDmaTDATA/TVALID/TLAST (output, AXI_WIDTH/1/1) and sysDmaTREADY (input, 1): master, toward the DMA engine.
REQ-010 SHALL have outputs sysDataPackets, sysMarkerPackets, sysTruncCount, each COUNT_WIDTH: statistics.

Function
REQ-011 SHALL merge the two slave streams into the master stream packet-atomically; beats of different packets are never interleaved.
REQ-012 SHALL implement the states IDLE, GRANT_DATA, GRANT_MARKER and DRAIN.
REQ-013 In IDLE, with exactly one slave TVALID high, SHALL go to that slave's GRANT state on the next cycle.
REQ-014 In IDLE, with both slave TVALIDs high, SHALL grant the slave not granted last (round-robin); the last-grant register resets to "marker", so data wins the first tie.
REQ-015 SHALL hold both slave TREADYs low in IDLE; no beat is accepted in the arbitration cycle.
REQ-016 In GRANT_x, the granted TREADY SHALL equal (!sysDmaTVALID || sysDmaTREADY), and the other slave TREADY SHALL be 0.
REQ-017 SHALL register the master output as one buffer stage; an accepted slave beat appears on sysDma* the following cycle.
REQ-018 The master output SHALL hold TDATA/TLAST stable while TVALID=1 and TREADY=0.
REQ-019 SHALL sustain one beat per cycle while both sides are ready.
REQ-020 SHALL keep a beat counter per granted packet; it clears on each grant.
REQ-021 On acceptance of a beat with TLAST=1, SHALL increment that slave's packet counter (wrapping) and return to IDLE.
REQ-022 If the MAX_BEATS-th beat is accepted without TLAST, SHALL force output TLAST=1 on that beat.
REQ-023 In that case, SHALL increment sysTruncCount (saturating at all-ones) and enter DRAIN.
REQ-024 In DRAIN, the granted TREADY SHALL be 1 unconditionally; beats SHALL be discarded (not output) until a TLAST beat is accepted, then IDLE.
REQ-025 A truncated packet SHALL NOT increment the slave's packet counter.
REQ-026 A packet with TLAST on exactly beat MAX_BEATS SHALL be passed intact and not counted as truncated.
REQ-027 A one-beat packet (TLAST on first beat) SHALL be legal and SHALL return to IDLE after that beat.
REQ-028 SHALL never drop or duplicate a beat outside DRAIN.

Reset
REQ-029 Reset SHALL force IDLE, last-grant=marker, sysDmaTVALID=0, sysDmaTLAST=0, both slave TREADY=0, beat counter=0, all statistics=0.
REQ-030 sysDmaTDATA reset value SHALL be 0.
REQ-031 Reset asserted mid-packet SHALL abandon the packet; after release, the first output beat SHALL be the first beat of a newly arbitrated packet.

Verification
REQ-032 Only marker sends a 3-beat packet A,B,C with sysDmaTREADY=1 -> output A,B,C on consecutive cycles; TLAST on C; sysMarkerPackets=1.
REQ-033 Both slaves valid from reset, three packets each -> output order data, marker, data, marker, data, marker with no interleaved beats.
REQ-034 sysDmaTREADY toggled 1/0 each cycle during a 4-beat data packet -> all 4 beats delivered in order; TDATA stable during stalls.
REQ-035 MAX_BEATS=4, data packet of 6 beats D0..D5 -> output D0..D3 with TLAST on D3; D4, D5 discarded; sysTruncCount=1; sysDataPackets=0.
REQ-036 MAX_BEATS=4, data packet of exactly 4 beats -> passed intact; sysTruncCount=0; sysDataPackets=1.
REQ-037 sysReset pulsed after beat 2 of a 5-beat packet, then a fresh 2-beat marker packet sent -> output is only the 2 marker beats; all counters restart from 0.
